// File: rtl/can_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : can_pkg
//  Purpose  : Shared CAN frame definitions (states, field lengths, CRC-15)
//             used by both the receive and transmit sides of the node.
//  Revision : 1.0 - initial release
// ============================================================================
package can_pkg;

  // Frame parser states, in bus order
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ID   = 3'd1,
    ST_CTRL = 3'd2,
    ST_DLC  = 3'd3,
    ST_DATA = 3'd4,
    ST_CRC  = 3'd5,
    ST_TAIL = 3'd6,
    ST_EOF  = 3'd7
  } can_state_e;

  // Field lengths in bits, sized to match the 7-bit field counter
  localparam logic [6:0] c_ID_LEN   = 7'd11;
  localparam logic [6:0] c_CTRL_LEN = 7'd2;
  localparam logic [6:0] c_DLC_LEN  = 7'd4;
  localparam logic [6:0] c_CRC_LEN  = 7'd15;
  localparam logic [6:0] c_TAIL_LEN = 7'd3;
  localparam logic [6:0] c_EOF_LEN  = 7'd7;

  // Tail bits, transmitted MSB first
  localparam logic [2:0]  c_TAIL_PATTERN = 3'b101;
  localparam logic [14:0] c_CRC15_POLY   = 15'h4599;

  // Error codes reported alongside the error pulse
  localparam logic [2:0] c_ERR_NONE = 3'd0;
  localparam logic [2:0] c_ERR_FORM = 3'd1;
  localparam logic [2:0] c_ERR_CRC  = 3'd2;
  localparam logic [2:0] c_ERR_BUS  = 3'd3;

  // One serial step of the CRC-15 LFSR
  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic bit_in);
    return {crc[13:0], 1'b0} ^ ((bit_in ^ crc[14]) ? c_CRC15_POLY : 15'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/can_crc15.sv
`default_nettype none
// ============================================================================
//  Module   : can_crc15
//  Purpose  : Serial CRC-15 LFSR, one bit per enabled clock; clr wins over en.
//  Revision : 1.0 - initial release
// ============================================================================
module can_crc15
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [14:0] crc
);

  // Advance the LFSR on each enabled bit, restart from zero on clear
  always_ff @(posedge clk) begin
    if (clr) begin
      crc <= 15'd0;
    end else if (en) begin
      crc <= crc15_step(crc, bit_in);
    end
  end

endmodule
`default_nettype wire

// File: rtl/can_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : can_frame_rx
//  Purpose  : CAN receive parser: decodes the differential bus, parses
//             standard frames, checks CRC-15 and offers frames on a
//             valid/ready port with form/CRC/bus error and overrun reporting.
//  Revision : 1.0 - initial release
// ============================================================================
module can_frame_rx
  import can_pkg::*;
#(
  parameter bit CHECK_CRC      = 1'b0,
  parameter int IDLE_RECESSIVE = 1,
  parameter int MAX_BYTES      = 8
) (
  input  logic        can_clk,
  input  logic        reset,
  input  logic        can_hi_in,
  input  logic        can_lo_in,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [10:0] rx_id,
  output logic [3:0]  rx_dlc,
  output logic [63:0] rx_data,
  output logic [14:0] rx_crc,
  output logic        rx_err,
  output logic [2:0]  rx_err_code,
  output logic        rx_overrun,
  output logic        rx_busy
);

  localparam logic [7:0] c_IDLE_REC  = 8'(IDLE_RECESSIVE);
  localparam logic [3:0] c_MAX_BYTES = 4'(MAX_BYTES);

  can_state_e  r_state, w_state_next;
  logic [6:0]  r_cnt, w_cnt_next;
  logic [7:0]  r_rec_cnt, w_rec_next;
  logic [10:0] r_id;
  logic [3:0]  r_dlc;
  logic [63:0] r_data;
  logic [14:0] r_crc_rx;
  logic [6:0]  r_data_bits;

  logic        w_dom, w_rec, w_inv, w_bit;
  logic        w_err, w_commit, w_crc_en, w_crc_clr, w_last, w_sof;
  logic [2:0]  w_err_code;
  logic [6:0]  w_len;
  logic [3:0]  w_dlc_full, w_nbytes;
  logic [14:0] w_crc, w_crc_full;
  logic [5:0]  w_data_idx;
  logic        w_tail_exp;

  // Bus level decode: dominant = 0, recessive = 1, equal levels are invalid
  assign w_dom = can_hi_in & ~can_lo_in;
  assign w_rec = ~can_hi_in & can_lo_in;
  assign w_inv = (can_hi_in == can_lo_in);
  assign w_bit = w_rec;

  assign w_dlc_full = {r_dlc[2:0], w_bit};
  assign w_nbytes   = (w_dlc_full > c_MAX_BYTES) ? c_MAX_BYTES : w_dlc_full;
  assign w_crc_full = {r_crc_rx[13:0], w_bit};
  // Byte k lands in [8k+:8]; within a byte the first bit is the MSB
  assign w_data_idx = {r_cnt[5:3], ~r_cnt[2:0]};
  assign w_tail_exp = c_TAIL_PATTERN[2'd2 - r_cnt[1:0]];
  assign w_crc_clr  = reset || (r_state == ST_IDLE);
  assign w_sof      = (r_state == ST_IDLE) && (w_state_next == ST_ID);
  assign w_last     = (r_cnt == w_len - 7'd1);
  assign rx_busy    = (r_state != ST_IDLE);

  can_crc15 u_crc (
    .clk    (can_clk),
    .clr    (w_crc_clr),
    .en     (w_crc_en),
    .bit_in (w_bit),
    .crc    (w_crc)
  );

  // Length of the field currently being received
  always_comb begin
    w_len = 7'd1;
    case (r_state)
      ST_ID:   w_len = c_ID_LEN;
      ST_CTRL: w_len = c_CTRL_LEN;
      ST_DLC:  w_len = c_DLC_LEN;
      ST_DATA: w_len = r_data_bits;
      ST_CRC:  w_len = c_CRC_LEN;
      ST_TAIL: w_len = c_TAIL_LEN;
      ST_EOF:  w_len = c_EOF_LEN;
      default: w_len = 7'd1;
    endcase
  end

  // Next-state, field counter, idle recessive counter and error/commit strobes
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 7'd1;
    w_rec_next   = r_rec_cnt;
    w_err        = 1'b0;
    w_err_code   = c_ERR_NONE;
    w_commit     = 1'b0;
    w_crc_en     = 1'b0;
    if (r_state == ST_IDLE) begin
      w_cnt_next = 7'd0;
      if (w_rec) begin
        if (r_rec_cnt != 8'hFF) w_rec_next = r_rec_cnt + 8'd1;
      end else begin
        // Invalid or dominant both break the recessive run
        w_rec_next = 8'd0;
        if (w_dom && (r_rec_cnt >= c_IDLE_REC)) w_state_next = ST_ID;
      end
    end else if (w_inv) begin
      w_err        = 1'b1;
      w_err_code   = c_ERR_BUS;
      w_state_next = ST_IDLE;
      w_rec_next   = 8'd0;
    end else begin
      case (r_state)
        ST_ID: begin
          w_crc_en = 1'b1;
          if (w_last) w_state_next = ST_CTRL;
        end
        ST_CTRL: begin
          w_crc_en = 1'b1;
          if (w_last) w_state_next = ST_DLC;
        end
        ST_DLC: begin
          w_crc_en = 1'b1;
          if (w_last) w_state_next = (w_nbytes == 4'd0) ? ST_CRC : ST_DATA;
        end
        ST_DATA: begin
          w_crc_en = 1'b1;
          if (w_last) w_state_next = ST_CRC;
        end
        ST_CRC: begin
          if (w_last) begin
            if (CHECK_CRC && (w_crc_full != w_crc)) begin
              w_err        = 1'b1;
              w_err_code   = c_ERR_CRC;
              w_state_next = ST_IDLE;
              w_rec_next   = 8'd0;
            end else begin
              w_state_next = ST_TAIL;
            end
          end
        end
        ST_TAIL: begin
          if (w_bit != w_tail_exp) begin
            w_err        = 1'b1;
            w_err_code   = c_ERR_FORM;
            w_state_next = ST_IDLE;
            w_rec_next   = 8'd0;
          end else if (w_last) begin
            w_state_next = ST_EOF;
          end
        end
        ST_EOF: begin
          if (w_dom) begin
            w_err        = 1'b1;
            w_err_code   = c_ERR_FORM;
            w_state_next = ST_IDLE;
            w_rec_next   = 8'd0;
          end else if (w_last) begin
            // The last EOF bit already counts as one recessive idle bit
            w_commit     = 1'b1;
            w_state_next = ST_IDLE;
            w_rec_next   = 8'd1;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
    if (w_state_next != r_state) w_cnt_next = 7'd0;
  end

  // State, field counter and recessive counter registers
  always_ff @(posedge can_clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 7'd0;
      r_rec_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_rec_cnt <= w_rec_next;
    end
  end

  // Shadow field capture; cleared at SOF so unused data bytes read as zero
  always_ff @(posedge can_clk) begin
    if (reset || w_sof) begin
      r_id        <= 11'd0;
      r_dlc       <= 4'd0;
      r_data      <= 64'd0;
      r_crc_rx    <= 15'd0;
      r_data_bits <= 7'd0;
    end else if (!w_inv) begin
      case (r_state)
        ST_ID:   r_id <= {r_id[9:0], w_bit};
        ST_DLC: begin
          r_dlc <= w_dlc_full;
          if (w_last) r_data_bits <= {w_nbytes, 3'b000};
        end
        ST_DATA: r_data[w_data_idx] <= w_bit;
        ST_CRC:  r_crc_rx <= w_crc_full;
        default: ;
      endcase
    end
  end

  // Output port: commit/handshake/overrun handling and the error pulse
  always_ff @(posedge can_clk) begin
    if (reset) begin
      rx_valid    <= 1'b0;
      rx_id       <= 11'd0;
      rx_dlc      <= 4'd0;
      rx_data     <= 64'd0;
      rx_crc      <= 15'd0;
      rx_err      <= 1'b0;
      rx_err_code <= 3'd0;
      rx_overrun  <= 1'b0;
    end else begin
      rx_err      <= w_err;
      rx_err_code <= w_err ? w_err_code : 3'd0;
      if (w_commit && (!rx_valid || rx_ready)) begin
        rx_valid <= 1'b1;
        rx_id    <= r_id;
        rx_dlc   <= r_dlc;
        rx_data  <= r_data;
        rx_crc   <= r_crc_rx;
      end else if (w_commit) begin
        rx_overrun <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_can_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_can_frame_rx
//  Purpose  : Scoreboard bench for can_frame_rx; two instances share the bus
//             (CRC ignored / CRC checked with an 11-bit idle requirement).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_can_frame_rx;

  logic can_clk = 1'b0;
  logic reset = 1'b1;
  logic can_hi_in = 1'b0;
  logic can_lo_in = 1'b1;
  logic rx_ready = 1'b0;

  logic        v[2];
  logic [10:0] id[2];
  logic [3:0]  dlc[2];
  logic [63:0] data[2];
  logic [14:0] crc[2];
  logic        err[2];
  logic [2:0]  code[2];
  logic        ovr[2];
  logic        busy[2];

  always #5 can_clk = ~can_clk;

  can_frame_rx #(.CHECK_CRC(1'b0), .IDLE_RECESSIVE(1), .MAX_BYTES(8)) dut0 (
    .can_clk(can_clk), .reset(reset), .can_hi_in(can_hi_in), .can_lo_in(can_lo_in),
    .rx_valid(v[0]), .rx_ready(rx_ready), .rx_id(id[0]), .rx_dlc(dlc[0]), .rx_data(data[0]),
    .rx_crc(crc[0]), .rx_err(err[0]), .rx_err_code(code[0]), .rx_overrun(ovr[0]), .rx_busy(busy[0]));

  can_frame_rx #(.CHECK_CRC(1'b1), .IDLE_RECESSIVE(11), .MAX_BYTES(8)) dut1 (
    .can_clk(can_clk), .reset(reset), .can_hi_in(can_hi_in), .can_lo_in(can_lo_in),
    .rx_valid(v[1]), .rx_ready(rx_ready), .rx_id(id[1]), .rx_dlc(dlc[1]), .rx_data(data[1]),
    .rx_crc(crc[1]), .rx_err(err[1]), .rx_err_code(code[1]), .rx_overrun(ovr[1]), .rx_busy(busy[1]));

  typedef struct {
    bit          is_err;
    logic [2:0]  code;
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [14:0] crc;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  n_cmp = 0;
  int  n_fail = 0;

  // Current frame as the model sees it
  bit          fb[$];
  logic [10:0] f_id;
  logic [3:0]  f_dlc;
  logic [63:0] f_data;
  logic [14:0] f_crc, f_gcrc;
  int          f_n;
  bit          rnd_ready = 1'b0;
  bit          fix_ready = 1'b1;
  bit          inv_lvl = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk_frame(input logic [14:0] c);
    ev_t e;
    e.is_err = 1'b0; e.code = 3'd0; e.id = f_id; e.dlc = f_dlc; e.data = f_data; e.crc = c;
    return e;
  endfunction

  function automatic ev_t mk_err(input logic [2:0] c);
    ev_t e;
    e.is_err = 1'b1; e.code = c; e.id = 11'd0; e.dlc = 4'd0; e.data = 64'd0; e.crc = 15'd0;
    return e;
  endfunction

  task automatic pop_ev(input int i, output ev_t e, output bit ok);
    ok = 1'b0;
    e = mk_err(3'd0);
    if (i == 0) begin
      if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
    end else begin
      if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
    end
  endtask

  // Build the bit list of a frame; CRC is the polynomial remainder of SOF..data
  // times x^15 modulo x^15+0x4599. crc_mode: 0 correct, 1 zero, 2 corrupted.
  task automatic make_frame(input logic [10:0] fid, input logic [3:0] fdlc,
                            input logic [63:0] fdat, input int crc_mode);
    logic [15:0] rem;
    f_id = fid;
    f_dlc = fdlc;
    f_n = (fdlc > 4'd8) ? 8 : int'(fdlc);
    f_data = 64'd0;
    for (int k = 0; k < f_n; k++) f_data[8*k +: 8] = fdat[8*k +: 8];
    fb.delete();
    fb.push_back(1'b0);
    for (int b = 10; b >= 0; b--) fb.push_back(fid[b]);
    fb.push_back(1'($urandom % 2));
    fb.push_back(1'($urandom % 2));
    for (int b = 3; b >= 0; b--) fb.push_back(fdlc[b]);
    for (int k = 0; k < f_n; k++)
      for (int b = 7; b >= 0; b--) fb.push_back(f_data[8*k + b]);
    rem = 16'd0;
    for (int j = 0; j < fb.size() + 15; j++) begin
      rem = {rem[14:0], (j < fb.size()) ? fb[j] : 1'b0};
      if (rem[15]) rem = rem ^ 16'hC599;
    end
    f_gcrc = rem[14:0];
    if (crc_mode == 0) f_crc = f_gcrc;
    else if (crc_mode == 1) f_crc = 15'd0;
    else f_crc = f_gcrc ^ 15'($urandom_range(1, 32767));
    for (int b = 14; b >= 0; b--) fb.push_back(f_crc[b]);
    fb.push_back(1'b1); fb.push_back(1'b0); fb.push_back(1'b1);
    for (int b = 0; b < 7; b++) fb.push_back(1'b1);
  endtask

  // Present one bus level for one bit time; returns just after the sampling edge
  task automatic drive(input bit hi, input bit lo);
    can_hi_in = hi;
    can_lo_in = lo;
    rx_ready = rnd_ready ? 1'($urandom % 2) : fix_ready;
    @(posedge can_clk);
    #1;
  endtask

  task automatic send_bit(input bit b);
    drive(~b, b);
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  // kind 0 clean, 1 invalid level at bit pos, 2 flip tail bit pos,
  // 3 dominant at EOF bit pos, 4 clean frame expected to be dropped (overrun)
  task automatic run_frame(input int kind, input int pos);
    int t0, e0;
    t0 = 33 + 8 * f_n;
    e0 = 36 + 8 * f_n;
    case (kind)
      0: begin
        q0.push_back(mk_frame(f_crc));
        q1.push_back((f_crc == f_gcrc) ? mk_frame(f_crc) : mk_err(3'd2));
        for (int j = 0; j < fb.size(); j++) send_bit(fb[j]);
        chk("commit_latency0", v[0], 1'b1);
        if (f_crc == f_gcrc) chk("commit_latency1", v[1], 1'b1);
      end
      1: begin
        q0.push_back(mk_err(3'd3)); q1.push_back(mk_err(3'd3));
        for (int j = 0; j < pos; j++) send_bit(fb[j]);
        drive(inv_lvl, inv_lvl);
        chk("err_latency_bus", {err[1], err[0]}, 2'b11);
      end
      2: begin
        q0.push_back(mk_err(3'd1)); q1.push_back(mk_err(3'd1));
        for (int j = 0; j < t0 + pos; j++) send_bit(fb[j]);
        send_bit(~fb[t0 + pos]);
        chk("err_latency_tail", {err[1], err[0]}, 2'b11);
      end
      3: begin
        q0.push_back(mk_err(3'd1)); q1.push_back(mk_err(3'd1));
        for (int j = 0; j < e0 + pos; j++) send_bit(fb[j]);
        send_bit(1'b0);
        chk("err_latency_eof", {err[1], err[0]}, 2'b11);
      end
      default: begin
        for (int j = 0; j < fb.size(); j++) send_bit(fb[j]);
      end
    endcase
    idle(12);
  endtask

  // Monitor: pops the expected event whenever a DUT hands over a frame or flags an error
  always @(negedge can_clk) begin
    ev_t e;
    bit  ok;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (v[i] && rx_ready) begin
          pop_ev(i, e, ok);
          if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_frame dut%0d: got id %0h expected nothing", i, id[i]);
          end else begin
            chk("frame_kind", 64'(e.is_err), 64'd0);
            chk("rx_id", id[i], e.id);
            chk("rx_dlc", dlc[i], e.dlc);
            chk("rx_data", data[i], e.data);
            chk("rx_crc", crc[i], e.crc);
          end
        end
        if (err[i]) begin
          pop_ev(i, e, ok);
          if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_err dut%0d: got code %0d expected nothing", i, code[i]);
          end else begin
            chk("err_kind", 64'(e.is_err), 64'd1);
            chk("rx_err_code", code[i], e.code);
          end
        end
      end
    end
  end

  initial begin
    int guard;
    int kind;
    // Reset state
    idle(3);
    chk("reset_valid", {v[1], v[0]}, 2'b00);
    chk("reset_err", {err[1], err[0], code[1], code[0]}, 8'd0);
    chk("reset_ovr_busy", {ovr[1], ovr[0], busy[1], busy[0]}, 4'd0);
    chk("reset_fields", {id[0], dlc[0], crc[0], id[1], dlc[1], crc[1]}, 60'd0);
    chk("reset_data", data[0] | data[1], 64'd0);
    reset = 1'b0;
    idle(12);

    // Reference frame with CRC=0 (accepted unchecked, CRC error when checked), then correct CRC
    make_frame(11'h123, 4'd2, 64'h1289, 1);
    run_frame(0, 0);
    make_frame(11'h123, 4'd2, 64'h1289, 0);
    run_frame(0, 0);

    // Overrun: two frames while the consumer stalls
    fix_ready = 1'b0;
    make_frame(11'h123, 4'd2, 64'h1289, 0);
    run_frame(0, 0);
    make_frame(11'h456, 4'd1, 64'h77, 0);
    run_frame(4, 0);
    chk("overrun_set", {ovr[1], ovr[0]}, 2'b11);
    chk("held_valid", {v[1], v[0]}, 2'b11);
    chk("held_id0", id[0], 11'h123);
    fix_ready = 1'b1;
    send_bit(1'b1);
    chk("valid_drop", {v[1], v[0]}, 2'b00);
    chk("overrun_sticky", {ovr[1], ovr[0]}, 2'b11);

    // Form errors in tail and EOF, then recovery
    make_frame(11'h2A5, 4'd3, 64'hC0FFEE, 0);
    run_frame(2, 1);
    make_frame(11'h0F0, 4'd0, 64'd0, 0);
    run_frame(3, 3);
    make_frame(11'h3C3, 4'd4, 64'hDEADBEEF, 0);
    run_frame(0, 0);

    // Invalid level during DATA, then DLC beyond 8
    inv_lvl = 1'b1;
    make_frame(11'h111, 4'd3, 64'hA1B2C3, 0);
    run_frame(1, 18 + int'($urandom_range(0, 23)));
    make_frame(11'h7FF, 4'd15, {$urandom, $urandom}, 0);
    run_frame(0, 0);

    // Reset in the middle of DATA while a frame is still held
    fix_ready = 1'b0;
    make_frame(11'h055, 4'd1, 64'h5A, 0);
    run_frame(0, 0);
    make_frame(11'h321, 4'd4, 64'h01020304, 0);
    for (int j = 0; j < 22; j++) send_bit(fb[j]);
    reset = 1'b1;
    send_bit(1'b1);
    chk("midreset_valid_ovr", {v[1], v[0], ovr[1], ovr[0]}, 4'd0);
    chk("midreset_busy_err", {busy[1], busy[0], err[1], err[0]}, 4'd0);
    chk("midreset_fields", data[0] | data[1] | 64'(id[0]) | 64'(id[1]), 64'd0);
    q0.delete();
    q1.delete();
    reset = 1'b0;
    fix_ready = 1'b1;
    idle(12);
    make_frame(11'h321, 4'd4, 64'h01020304, 0);
    run_frame(0, 0);

    // Randomized frames with random consumer back-pressure
    rnd_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      guard = 0;
      while ((v[0] || v[1]) && guard < 200) begin
        send_bit(1'b1);
        guard++;
      end
      if (guard >= 200) begin
        n_cmp++; n_fail++;
        $display("FAIL drain_timeout: got valid %0b%0b expected 00", v[1], v[0]);
      end
      kind = int'($urandom_range(0, 5));
      if (kind > 3) kind = 0;
      inv_lvl = 1'($urandom % 2);
      make_frame(11'($urandom), 4'($urandom), {$urandom, $urandom},
                 (kind == 0 && ($urandom % 3 == 0)) ? 2 : 0);
      case (kind)
        1: run_frame(1, int'($urandom_range(1, 42 + 8 * f_n)));
        2: run_frame(2, int'($urandom_range(0, 2)));
        3: run_frame(3, int'($urandom_range(0, 6)));
        default: run_frame(0, 0);
      endcase
    end
    rnd_ready = 1'b0;
    fix_ready = 1'b1;
    idle(20);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("no_overrun_random", {ovr[1], ovr[0]}, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
